// File: rtl/serial_out_pkg.sv
// Shared encodings and defaults for the serial output channel and its bit timer.
package serial_out_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01
    } state_e;

    localparam int   SEL_W        = 4;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;
    localparam int   DEF_FAST_DIV = 10;
    localparam int   DEF_SLOW_DIV = 40;
endpackage

// File: rtl/serial_out_channel_bit_timer.sv
// Per-bit cycle counter: counts 0..div-1 and flags the last cycle of each bit period.
module bit_timer
    import serial_out_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_tick_nxt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // i_en and i_div describe the coming cycle, so the tick can be registered.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        if (!i_en || i_restart || tick_q) begin
            cnt_d = '0;
        end
        tick_d = i_en && (cnt_d == (i_div - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick     = tick_q;
    assign o_tick_nxt = tick_d;
endmodule

// File: rtl/serial_out_channel.sv
// One output pin of the serial output engine: LSB-first pattern with per-bit speed.
module serial_out_channel
    import serial_out_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int CH_ID    = 0,
    parameter int FAST_DIV = DEF_FAST_DIV,
    parameter int SLOW_DIV = DEF_SLOW_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [SEL_W-1:0]    i_sel_out,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    output logic                o_serial,
    output logic                o_busy,
    output logic                o_bit_tick,
    output logic                o_done_tick
);
    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);
    localparam int IDX_W   = $clog2(DATA_BIT);
    localparam logic [CNT_W-1:0] FAST_C   = CNT_W'(FAST_DIV);
    localparam logic [CNT_W-1:0] SLOW_C   = CNT_W'(SLOW_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_BIT-1:0] pat_q, pat_d, freq_q, freq_d;
    logic                mode_q, mode_d;
    logic [DATA_BIT-1:0] pend_pat_q, pend_pat_d, pend_freq_q, pend_freq_d;
    logic                pend_mode_q, pend_mode_d, pend_valid_q, pend_valid_d;
    logic                serial_q, serial_d, busy_q, busy_d, done_q, done_d;
    logic                accept, stop_cmd, start_cmd, pend_cmd;
    logic                tick, tick_nxt;
    logic [CNT_W-1:0]    div_nxt;

    assign accept    = i_load && (i_sel_out == SEL_W'(CH_ID));
    assign stop_cmd  = accept && i_stop;
    assign start_cmd = accept && i_start && !i_stop;
    assign pend_cmd  = accept && !i_start && !i_stop;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pat_d        = pat_q;
        freq_d       = freq_q;
        mode_d       = mode_q;
        pend_pat_d   = pend_pat_q;
        pend_freq_d  = pend_freq_q;
        pend_mode_d  = pend_mode_q;
        pend_valid_d = pend_valid_q;

        if (state_q == S_RUN && tick) begin
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + 1'b1;
            end else if (mode_q == MODE_REPEAT) begin
                idx_d = '0;
                if (pend_valid_q) begin
                    pat_d        = pend_pat_q;
                    freq_d       = pend_freq_q;
                    mode_d       = pend_mode_q;
                    pend_valid_d = 1'b0;
                end
            end else begin
                state_d      = S_IDLE;
                idx_d        = '0;
                pend_valid_d = 1'b0;
            end
        end

        // Commands are applied after the wrap so a new pending survives a same-cycle wrap.
        if (pend_cmd) begin
            pend_pat_d   = i_output_pattern;
            pend_freq_d  = i_freq_pattern;
            pend_mode_d  = i_mode;
            pend_valid_d = 1'b1;
        end
        if (start_cmd) begin
            pat_d   = i_output_pattern;
            freq_d  = i_freq_pattern;
            mode_d  = i_mode;
            idx_d   = '0;
            state_d = S_RUN;
        end
        if (stop_cmd && state_q == S_RUN) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            pend_valid_d = 1'b0;
        end
    end

    // Outputs are computed from next-state values so they can be registered without lag.
    assign div_nxt  = freq_d[idx_d] ? SLOW_C : FAST_C;
    assign busy_d   = (state_d == S_RUN);
    assign serial_d = busy_d && pat_d[idx_d];
    assign done_d   = busy_d && (mode_d == MODE_ONESHOT) && (idx_d == LAST_IDX) && tick_nxt;

    bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (busy_d),
        .i_restart  (start_cmd),
        .i_div      (div_nxt),
        .o_tick     (tick),
        .o_tick_nxt (tick_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pat_q        <= '0;
            freq_q       <= '0;
            mode_q       <= MODE_ONESHOT;
            pend_pat_q   <= '0;
            pend_freq_q  <= '0;
            pend_mode_q  <= MODE_ONESHOT;
            pend_valid_q <= 1'b0;
            serial_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pat_q        <= pat_d;
            freq_q       <= freq_d;
            mode_q       <= mode_d;
            pend_pat_q   <= pend_pat_d;
            pend_freq_q  <= pend_freq_d;
            pend_mode_q  <= pend_mode_d;
            pend_valid_q <= pend_valid_d;
            serial_q     <= serial_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_serial    = serial_q;
    assign o_busy      = busy_q;
    assign o_bit_tick  = tick;
    assign o_done_tick = done_q;
endmodule

// File: tb/tb_serial_out_channel.sv
// Bench for serial_out_channel: per-cycle scoreboard of {serial,busy,tick,done}.
module tb_serial_out_channel;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_load, i_start, i_stop, i_mode;
    logic [7:0] i_output_pattern, i_freq_pattern;
    logic [3:0] i_sel_out;
    logic       o_serial, o_busy, o_bit_tick, o_done_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [7:0] pat;
        logic [7:0] freq;
        logic [3:0] sel;
        logic       start;
        logic       stop;
        logic       mode;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    serial_out_channel #(
        .DATA_BIT(8), .CH_ID(3), .FAST_DIV(2), .SLOW_DIV(5)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_load           (i_load),
        .i_output_pattern (i_output_pattern),
        .i_freq_pattern   (i_freq_pattern),
        .i_sel_out        (i_sel_out),
        .i_start          (i_start),
        .i_stop           (i_stop),
        .i_mode           (i_mode),
        .o_serial         (o_serial),
        .o_busy           (o_busy),
        .o_bit_tick       (o_bit_tick),
        .o_done_tick      (o_done_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name);
        logic [3:0] a, e;
        a = {o_serial, o_busy, o_bit_tick, o_done_tick};
        e = (exp_q.size() == 0) ? 4'b0000 : exp_q.pop_front();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: serial/busy/tick/done got %b required %b", name, cyc, a, e);
        end
    endtask

    task automatic run_checks(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            check(name);
            step();
        end
    endtask

    task automatic drain(input string name);
        forever begin
            check(name);
            if (exp_q.size() == 0) break;
            step();
        end
    endtask

    // Expected waveform of one pass, expanded bit by bit from the command.
    task automatic push_pass(input logic [7:0] pat, input logic [7:0] freq, input logic oneshot);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = freq[i] ? 5 : 2;
            for (int c = 0; c < d; c++) begin
                exp_q.push_back({pat[i], 1'b1, (c == d - 1), oneshot && (i == 7) && (c == d - 1)});
            end
        end
        if (oneshot) begin
            exp_q.push_back(4'b0000);
            exp_q.push_back(4'b0000);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
    endtask

    task automatic drive(input logic [7:0] pat, input logic [7:0] freq, input logic [3:0] sel,
                         input logic start, input logic stop, input logic mode);
        i_load           = 1'b1;
        i_output_pattern = pat;
        i_freq_pattern   = freq;
        i_sel_out        = sel;
        i_start          = start;
        i_stop           = stop;
        i_mode           = mode;
    endtask

    task automatic idle_in();
        i_load  = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        vecs[0] = '{8'hA5, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 16};
        vecs[1] = '{8'hFF, 8'h0F, 4'd3, 1'b1, 1'b0, 1'b0, 28};
        vecs[2] = '{8'h3C, 8'hFF, 4'd3, 1'b1, 1'b0, 1'b0, 40};
        vecs[3] = '{8'hA5, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{8'hC3, 8'h00, 4'd3, 1'b0, 1'b1, 1'b0, 0};
        vecs[5] = '{8'h96, 8'h5A, 4'd3, 1'b1, 1'b0, 1'b0, 28};

        rst_n = 1'b0;
        i_output_pattern = '0;
        i_freq_pattern   = '0;
        i_sel_out        = '0;
        i_mode           = 1'b0;
        idle_in();
        #3;
        check("reset_state");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Table of one-shot commands, including ones the channel must ignore.
        foreach (vecs[v]) begin
            drive(vecs[v].pat, vecs[v].freq, vecs[v].sel, vecs[v].start, vecs[v].stop, vecs[v].mode);
            if (vecs[v].exp_busy != 0) push_pass(vecs[v].pat, vecs[v].freq, 1'b1);
            else push_idle(4);
            step();
            idle_in();
            busy_cnt = 0;
            forever begin
                check($sformatf("vec%0d", v));
                busy_cnt += int'(o_busy);
                if (exp_q.size() == 0) break;
                step();
            end
            n_checks++;
            if (busy_cnt != vecs[v].exp_busy) begin
                n_fail++;
                $display("FAIL vec%0d_busy_len: got %0d required %0d", v, busy_cnt, vecs[v].exp_busy);
            end
        end

        // Repeat mode with a pending pattern picked up at the wrap.
        drive(8'h01, 8'h00, 4'd3, 1'b1, 1'b0, 1'b1);
        push_pass(8'h01, 8'h00, 1'b0);
        step();
        idle_in();
        run_checks(6, "rep_pass1");
        check("rep_pass1");
        drive(8'h80, 8'h00, 4'd3, 1'b0, 1'b0, 1'b1);
        push_pass(8'h80, 8'h00, 1'b0);
        push_pass(8'h80, 8'h00, 1'b0);
        step();
        idle_in();
        run_checks(9 + 16 + 10, "rep_pass2");
        check("rep_pass3");
        drive(8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 1'b0);
        step();
        idle_in();
        exp_q.delete();
        push_idle(3);
        run_checks(3, "rep_stop");

        // Simultaneous start+stop aborts; a later start alone begins at bit 0.
        drive(8'hA5, 8'h00, 4'd3, 1'b1, 1'b0, 1'b1);
        push_pass(8'hA5, 8'h00, 1'b0);
        step();
        idle_in();
        run_checks(5, "abort_run");
        check("abort_run");
        drive(8'hFF, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        exp_q.delete();
        push_idle(2);
        run_checks(2, "abort_idle");
        drive(8'h5A, 8'h0F, 4'd3, 1'b1, 1'b0, 1'b0);
        push_pass(8'h5A, 8'h0F, 1'b1);
        step();
        idle_in();
        drain("restart_pass");

        // Asynchronous reset in the middle of a repeat pass.
        drive(8'h5A, 8'h00, 4'd3, 1'b1, 1'b0, 1'b1);
        push_pass(8'h5A, 8'h00, 1'b0);
        step();
        idle_in();
        run_checks(8, "rst_pre");
        check("rst_bit4");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_async");
        step();
        push_idle(2);
        run_checks(2, "rst_held");
        rst_n = 1'b1;
        push_idle(4);
        run_checks(4, "rst_after");
        drive(8'hA5, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0);
        push_pass(8'hA5, 8'h00, 1'b1);
        step();
        idle_in();
        drain("post_rst_pass");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_out_channel.md
Name: serial_out_channel

Overview:
- One output channel of the differential-frequency serial output engine; sits directly downstream of the UART packet decoder.
- Accepts decoded commands (output pattern, frequency pattern, channel select, start/stop/mode) on the decoder's done tick.
- Serializes the pattern LSB-first; each bit's duration is chosen per bit by the frequency pattern.
- One instance per physical output pin, distinguished by CH_ID.

Parameters:
- DATA_BIT, 32, pattern width in bits (>=2).
- CH_ID, 0, channel number compared against i_sel_out (0..15).
- FAST_DIV, 10, clk cycles per bit when the frequency bit is 0 (>=1).
- SLOW_DIV, 40, clk cycles per bit when the frequency bit is 1 (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- i_load  in  1  command strobe, one cycle (decoder done tick)
- i_output_pattern  in  DATA_BIT  serial data pattern
- i_freq_pattern  in  DATA_BIT  per-bit speed select
- i_sel_out  in  4  target channel
- i_start  in  1  start command flag
- i_stop  in  1  stop command flag
- i_mode  in  1  0 = one-shot, 1 = continuous repeat
- o_serial  out  1  serial output pin
- o_busy  out  1  high while in RUN
- o_bit_tick  out  1  pulse on the last clk of every bit period
- o_done_tick  out  1  one-cycle pulse when a one-shot pass completes

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; pattern, pending and counter registers cleared; pending_valid 0.
- A command is accepted only when i_load=1 and i_sel_out==CH_ID. Otherwise all inputs are ignored.
- Accepted-command priority:
  - i_stop=1: abort; next cycle state IDLE, o_serial=0, o_busy=0, no done tick. Pending is cleared. Stop wins over a simultaneous start. Stop while IDLE is a no-op.
  - i_start=1, i_stop=0: load active pattern, freq and mode registers; bit index=0, cycle counter=0; state RUN. Applies from IDLE or mid-RUN (restart with no gap, no done tick).
  - Neither flag: store patterns and mode into pending registers, set pending_valid. Consumed at the next repeat wrap; discarded if a one-shot pass completes.
- Latency: command accepted at cycle N; o_serial shows new bit 0 from cycle N+1.
- States:
  - IDLE: o_serial=0.
  - RUN: o_serial=pattern[idx]. Bit duration is div = freq[idx] ? SLOW_DIV : FAST_DIV.
- Counter rules:
  - Counter runs 0..div-1. At div-1: o_bit_tick=1, counter resets to 0, idx advances.
  - Counter width $clog2(max(FAST_DIV,SLOW_DIV)+1). Index width $clog2(DATA_BIT).
  - DIV=1: every clk is a bit; o_bit_tick is high continuously in RUN.
- End of last bit (idx==DATA_BIT-1, counter==div-1):
  - mode=0: o_done_tick=1 in that same cycle; next cycle IDLE, o_serial=0.
  - mode=1: idx wraps to 0 with no idle gap. If pending_valid, load pending into active registers (including mode) and clear pending_valid.
- o_busy is high exactly while state==RUN.
- o_serial, o_busy and o_done_tick are registered, glitch-free. o_bit_tick is registered or combinationally decoded from registers only.
- Reset asserted mid-pass forces IDLE immediately; no done tick is produced.

Decomposition:
- Shared package serial_out_pkg:
  - state encodings S_IDLE=2'b00, S_RUN=2'b01.
  - SEL_W=4, MODE_ONESHOT=0, MODE_REPEAT=1.
  - default FAST_DIV/SLOW_DIV constants.
- One sub-module bit_timer:
  - loadable down/up counter taking div and a restart input, producing the end-of-bit tick.
  - Instantiated once inside serial_out_channel.

Test Plan:
Bench setting: DATA_BIT=8, CH_ID=3, FAST_DIV=2, SLOW_DIV=5.
1. Load sel=3, start=1, mode=0, pattern=8'hA5, freq=8'h00 -> o_serial = 1,0,1,0,0,1,0,1 (LSB first), 2 clks each starting cycle N+1. o_done_tick pulses at cycle N+16, then IDLE with o_serial=0.
2. pattern=8'hFF, freq=8'h0F, mode=0 -> o_serial high for 4*5+4*2=28 clks. o_bit_tick pulses 8 times. One done tick.
3. mode=1, pattern=8'h01, freq=0; mid-pass send sel=3 with no flags, pattern=8'h80 -> first pass completes as 8'h01; from the wrap o_serial follows 8'h80 with no gap. No done tick.
4. Command with sel=2, start=1 while IDLE -> no change: o_busy=0, o_serial=0.
5. During RUN, i_load with start=1 and stop=1 -> IDLE next cycle, o_serial=0, no done tick. A subsequent start=1 alone restarts at bit 0.
6. Assert rst_n low at bit 4 of a repeat pass -> all outputs 0 immediately. After release the block stays IDLE until a new start.
